key_rot_sched: RTL and testbench

Parametrised round-key rotation sequencer for the TDES key path. It loads the post-PC-1 C/D key halves and steps them through a programmable per-round rotation schedule. Rotation is left for encrypt and right for decrypt. It presents one round's C/D pair per round under a valid/ready handshake to the downstream PC-2/round logic. It replaces the externally driven per-cycle shift-code scheme: round counting, direction and schedule are internal.

---
 rtl/key_rot_sched.sv | 122 ++++++++++++
 tb/tb_key_rot_sched.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/key_rot_sched.sv
// rtl/key_rot_sched.sv - TDES round-key C/D rotation sequencer with valid/ready output
module key_rot_sched #(
  parameter int          HALF_W    = 28,
  parameter int          ROUNDS    = 16,
  parameter logic [31:0] SHIFT_MAP = 32'h0000_7EFC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              decrypt,
  input  logic              abort,
  input  logic [HALF_W-1:0] key_c,
  input  logic [HALF_W-1:0] key_d,
  input  logic              rk_ready,
  output logic              rk_valid,
  output logic [4:0]        rk_round,
  output logic [HALF_W-1:0] rk_c,
  output logic [HALF_W-1:0] rk_d,
  output logic              busy,
  output logic              done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [4:0] LAST_ROUND = 5'(ROUNDS);
  localparam logic [4:0] DEC_BASE   = 5'(ROUNDS + 1);

  state_t            state, state_n;
  logic              dec_q, dec_n;
  logic              valid_n, done_n;
  logic [4:0]        round_n;
  logic [HALF_W-1:0] c_n, d_n;

  // Rotation amount for round r: encrypt reads SHIFT_MAP[r-1]; decrypt walks
  // the map backwards and skips the first rotation so keys come out reversed.
  function automatic logic [1:0] amt_for(input logic [4:0] r, input logic dec);
    logic [4:0] idx;
    if (dec && (r == 5'd1)) begin
      return 2'd0;
    end
    idx = dec ? (DEC_BASE - r) : (r - 5'd1);
    return SHIFT_MAP[idx] ? 2'd2 : 2'd1;
  endfunction

  // Circular rotate by 0..2; MSB is the first key bit, so "left" moves toward it.
  function automatic logic [HALF_W-1:0] rot(input logic [HALF_W-1:0] x,
                                            input logic [1:0] n,
                                            input logic right);
    case (n)
      2'd1:    return right ? {x[0], x[HALF_W-1:1]} : {x[HALF_W-2:0], x[HALF_W-1]};
      2'd2:    return right ? {x[1:0], x[HALF_W-1:2]} : {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]};
      default: return x;
    endcase
  endfunction

  // State and output registers; reset clears everything to an idle, zeroed block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      dec_q    <= 1'b0;
      rk_valid <= 1'b0;
      rk_round <= 5'd0;
      rk_c     <= '0;
      rk_d     <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      dec_q    <= dec_n;
      rk_valid <= valid_n;
      rk_round <= round_n;
      rk_c     <= c_n;
      rk_d     <= d_n;
      done     <= done_n;
    end
  end

  // Next-state logic: abort beats start and the handshake; RUN advances one round per accept.
  always_comb begin
    state_n = state;
    dec_n   = dec_q;
    valid_n = rk_valid;
    round_n = rk_round;
    c_n     = rk_c;
    d_n     = rk_d;
    done_n  = 1'b0;
    if (abort) begin
      state_n = IDLE;
      valid_n = 1'b0;
      round_n = 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dec_n   = decrypt;
            c_n     = rot(key_c, amt_for(5'd1, decrypt), decrypt);
            d_n     = rot(key_d, amt_for(5'd1, decrypt), decrypt);
            round_n = 5'd1;
            valid_n = 1'b1;
            state_n = RUN;
          end
        end
        RUN: begin
          if (rk_valid && rk_ready) begin
            if (rk_round == LAST_ROUND) begin
              valid_n = 1'b0;
              done_n  = 1'b1;
              state_n = IDLE;
            end else begin
              round_n = rk_round + 5'd1;
              c_n     = rot(rk_c, amt_for(rk_round + 5'd1, dec_q), dec_q);
              d_n     = rot(rk_d, amt_for(rk_round + 5'd1, dec_q), dec_q);
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_key_rot_sched.sv
// tb/tb_key_rot_sched.sv - directed table-driven bench for key_rot_sched
module tb_key_rot_sched;

  localparam logic [27:0] KC = 28'hF0CCAAF;
  localparam logic [27:0] KD = 28'h556678F;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, decrypt, abort, rk_ready;
  logic [27:0] key_c, key_d, rk_c, rk_d;
  logic        rk_valid, busy, done;
  logic [4:0]  rk_round;

  logic        s_start, s_decrypt, s_abort, s_ready;
  logic [7:0]  s_key_c, s_key_d, s_c, s_d;
  logic        s_valid, s_busy, s_done;
  logic [4:0]  s_round;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int rnd;
    int cum;
  } des_vec_t;

  typedef struct {
    logic       dec;
    int         rnd;
    logic [7:0] exp_c;
    logic [7:0] exp_d;
  } small_vec_t;

  des_vec_t   des_tab[16];
  small_vec_t small_tab[8];

  key_rot_sched dut (
    .clk(clk), .rst_n(rst_n), .start(start), .decrypt(decrypt), .abort(abort),
    .key_c(key_c), .key_d(key_d), .rk_ready(rk_ready), .rk_valid(rk_valid),
    .rk_round(rk_round), .rk_c(rk_c), .rk_d(rk_d), .busy(busy), .done(done)
  );

  key_rot_sched #(.HALF_W(8), .ROUNDS(4), .SHIFT_MAP(32'h0000_0006)) u_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .decrypt(s_decrypt), .abort(s_abort),
    .key_c(s_key_c), .key_d(s_key_d), .rk_ready(s_ready), .rk_valid(s_valid),
    .rk_round(s_round), .rk_c(s_c), .rk_d(s_d), .busy(s_busy), .done(s_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  function automatic logic [27:0] rotl28(input logic [27:0] x, input int n);
    logic [27:0] y = x;
    for (int i = 0; i < n; i++) y = {y[26:0], y[27]};
    return y;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full DES-size schedule; optional stall, ignored start pulse, abort, start-at-last.
  task automatic run_des(input logic dec, input int stall_at, input int pulse_at,
                         input int abort_at, input logic start_last);
    logic [27:0] ec, ed;
    start = 1'b1; decrypt = dec; key_c = KC; key_d = KD; rk_ready = 1'b1;
    step();
    start = 1'b0;
    ec = KC; ed = KD;
    for (int r = 1; r <= 16; r++) begin
      ec = rotl28(KC, dec ? des_tab[16-r].cum : des_tab[r-1].cum);
      ed = rotl28(KD, dec ? des_tab[16-r].cum : des_tab[r-1].cum);
      chk($sformatf("valid_r%0d", r), 32'(rk_valid), 32'd1);
      chk($sformatf("round_r%0d", r), 32'(rk_round), 32'(r));
      chk($sformatf("c_r%0d_dec%0d", r, dec), 32'(rk_c), 32'(ec));
      chk($sformatf("d_r%0d_dec%0d", r, dec), 32'(rk_d), 32'(ed));
      chk($sformatf("busy_r%0d", r), 32'(busy), 32'd1);
      chk($sformatf("done_low_r%0d", r), 32'(done), 32'd0);
      if (r == 1 && !dec) chk("enc_r1_literal", 32'(rk_c), 32'h0E19955F);
      if (r == 16 && dec) chk("dec_r16_literal", 32'(rk_d), 32'h0AACCF1E);
      if (r == stall_at) begin
        rk_ready = 1'b0;
        repeat (3) begin
          step();
          chk("stall_round", 32'(rk_round), 32'(r));
          chk("stall_c", 32'(rk_c), 32'(ec));
          chk("stall_d", 32'(rk_d), 32'(ed));
          chk("stall_valid", 32'(rk_valid), 32'd1);
        end
        rk_ready = 1'b1;
      end
      if (r == pulse_at) begin
        start = 1'b1; decrypt = ~dec;
      end
      if (r == abort_at) begin
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_valid", 32'(rk_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_round", 32'(rk_round), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_c_hold", 32'(rk_c), 32'(ec));
        step();
        chk("abort_done_next", 32'(done), 32'd0);
        return;
      end
      if (r == 16 && start_last) start = 1'b1;
      step();
      start = 1'b0; decrypt = dec;
    end
    chk("done_pulse", 32'(done), 32'd1);
    chk("end_valid", 32'(rk_valid), 32'd0);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_c_hold", 32'(rk_c), 32'(ec));
    step();
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_after_end", 32'(rk_valid), 32'd0);
  endtask

  initial begin
    des_tab = '{'{1, 1}, '{2, 2}, '{3, 4}, '{4, 6}, '{5, 8}, '{6, 10}, '{7, 12}, '{8, 14},
                '{9, 15}, '{10, 17}, '{11, 19}, '{12, 21}, '{13, 23}, '{14, 25}, '{15, 27}, '{16, 28}};
    small_tab = '{'{1'b0, 1, 8'h03, 8'h20}, '{1'b0, 2, 8'h0C, 8'h80},
                  '{1'b0, 3, 8'h30, 8'h02}, '{1'b0, 4, 8'h60, 8'h04},
                  '{1'b1, 1, 8'h81, 8'h10}, '{1'b1, 2, 8'hC0, 8'h08},
                  '{1'b1, 3, 8'h30, 8'h02}, '{1'b1, 4, 8'h0C, 8'h80}};

    rst_n = 1'b0; start = 1'b0; decrypt = 1'b0; abort = 1'b0; rk_ready = 1'b0;
    key_c = '0; key_d = '0;
    s_start = 1'b0; s_decrypt = 1'b0; s_abort = 1'b0; s_ready = 1'b1;
    s_key_c = 8'h81; s_key_d = 8'h10;
    #23;
    chk("rst_valid", 32'(rk_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_round", 32'(rk_round), 32'd0);
    chk("rst_c", 32'(rk_c), 32'd0);
    chk("rst_d", 32'(rk_d), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    run_des(1'b0, 0, 0, 0, 1'b0);
    run_des(1'b1, 5, 8, 0, 1'b1);
    run_des(1'b0, 5, 8, 0, 1'b0);
    run_des(1'b0, 0, 0, 10, 1'b0);

    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_valid", 32'(rk_valid), 32'd0);
    chk("start_abort_busy", 32'(busy), 32'd0);
    chk("start_abort_round", 32'(rk_round), 32'd0);

    run_des(1'b0, 0, 0, 0, 1'b0);

    start = 1'b1; decrypt = 1'b0;
    step();
    start = 1'b0;
    repeat (3) step();
    chk("pre_rst_round", 32'(rk_round), 32'd4);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(rk_valid), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_round", 32'(rk_round), 32'd0);
    chk("async_rst_c", 32'(rk_c), 32'd0);
    chk("async_rst_d", 32'(rk_d), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_idle", 32'(rk_valid), 32'd0);

    for (int i = 0; i < 8; i++) begin
      if (small_tab[i].rnd == 1) begin
        s_start = 1'b1; s_decrypt = small_tab[i].dec;
        step();
        s_start = 1'b0;
      end
      chk($sformatf("small_round_%0d", i), 32'(s_round), 32'(small_tab[i].rnd));
      chk($sformatf("small_c_%0d", i), 32'(s_c), 32'(small_tab[i].exp_c));
      chk($sformatf("small_d_%0d", i), 32'(s_d), 32'(small_tab[i].exp_d));
      step();
      if (small_tab[i].rnd == 4) begin
        chk($sformatf("small_done_%0d", i), 32'(s_done), 32'd1);
        chk($sformatf("small_idle_%0d", i), 32'(s_valid), 32'd0);
        step();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
